mcycle_cpu: RTL and testbench
=============================

MCYCLE_CPU -- requirements
Module: mcycle_cpu

Interface
REQ-001 Parameter DW, default 8, data and register width in bits (4..32).
REQ-002 Parameter NREG, default 8, number of general registers (2..16).
REQ-003 Parameter PCW, default 4, program counter width in bits (1..8).
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 imem_addr  output  PCW  instruction address, equals pc.
REQ-007 imem_rdata  input  16  instruction word, combinational from imem_addr.
REQ-008 dmem_addr  output  4  data memory address.
REQ-009 dmem_wdata  output  DW  store data.
REQ-010 dmem_rdata  input  DW  load data, valid when dmem_ready high.
REQ-011 dmem_we / dmem_re  output  1 each  store / load request, held until accepted.
REQ-012 dmem_ready  input  1  memory accepts the pending request this cycle.
REQ-013 halted  output  1  core stopped on HALT.
REQ-014 carry  output  1  carry/borrow flag.
REQ-015 illegal  output  1  one-cycle pulse on an undefined opcode.

Function
REQ-016 Instruction fields: op=[15:12], Rd=[11:8], Rn=[7:4], Rm=[3:0].
REQ-017 FSM states FETCH, EXEC, MEM, HALT; FETCH latches imem_rdata into the instruction register and always goes to EXEC.
REQ-018 Op 0 ADD Rd=Rn+Rm; 1 ADDI Rd=Rn+zero-extended Rm field; 2 AND; 3 OR; 4 MUL Rd=low DW bits of Rn*Rm; 8 SUB Rd=Rn-Rm; all modulo 2^DW.
REQ-019 ALU ops write Rd and advance pc in EXEC, then return to FETCH: 2 cycles per instruction.
REQ-020 carry updated only by ADD/ADDI (bit DW of the unsigned sum) and SUB (1 when Rn<Rm unsigned); held otherwise.
REQ-021 Op 5 NOP and op 0xB..0xF: no register/flag change, pc+1; 0xB..0xF also pulse illegal for the EXEC cycle.
REQ-022 Op 6 STUR: EXEC moves to MEM; MEM drives dmem_addr=Rd field, dmem_wdata=R[Rn], dmem_we=1 until dmem_ready sampled high.
REQ-023 Op 7 LDUR: MEM drives dmem_addr=Rd field, dmem_re=1; on the cycle dmem_ready is high, R[Rn]=dmem_rdata, pc+1, go FETCH.
REQ-024 Memory ops take 3 cycles with ready already high, +1 per wait cycle; no timeout.
REQ-025 dmem_we and dmem_re never high together and are 0 outside MEM.
REQ-026 Op 0xA BNZ: if R[Rd]!=0, pc={Rn,Rm} truncated to PCW, else pc+1.
REQ-027 Op 9 HALT: enter HALT, halted=1, pc frozen; only rst leaves HALT.
REQ-028 pc increments wrap modulo 2^PCW.
REQ-029 Register index >= NREG: reads return 0, writes discarded.
REQ-030 Same register as source and destination: sources read before the write.

Reset
REQ-031 rst high: immediately, regardless of clk, state=FETCH, pc=0, all registers 0, carry=0, halted=0, illegal=0, dmem_we=dmem_re=0, dmem_addr=0, dmem_wdata=0.
REQ-032 rst asserted during MEM aborts the access; no register write occurs.
REQ-033 First fetch from address 0 on the first rising edge after rst deasserts.

Verification
REQ-034 ADDI R1=R0+5; ADDI R2=R0+3; ADD R3=R1+R2; HALT -> R3=8, carry=0, halted=1 after 7 rising edges.
REQ-035 DW=8: R1=0xFF via MUL/ADDI sequence, ADDI R1=R1+1 -> R1=0x00, carry=1; SUB R4=R0-R1 with R1=1 -> R4=0xFF, carry=1.
REQ-036 STUR mem[3]=R1(0x2A) with dmem_ready low 2 cycles -> dmem_we high exactly 3 cycles, addr=3, wdata=0x2A; LDUR R5=mem[3] -> R5=0x2A.
REQ-037 R1=2, loop ADDI R1=R1-1 via SUB, BNZ R1 to loop -> loop body executes twice, then falls through; PCW=4 program running past 15 wraps pc to 0.
REQ-038 rst pulsed mid-LDUR while dmem_ready low -> dmem_re drops same cycle, R[Rn] unchanged, pc=0.
REQ-039 Opcode 0xC -> illegal high one cycle, registers unchanged, pc+1; NREG=4 write to R6 discarded, read of R6 returns 0.

Source files
------------

// File: rtl/mcycle_cpu.sv
// Multi-cycle 16-bit-instruction CPU: FETCH/EXEC/MEM/HALT sequencer with a small
// register file, carry flag and a ready-handshaked data memory port.
module mcycle_cpu #(
  parameter int DW   = 8,
  parameter int NREG = 8,
  parameter int PCW  = 4
) (
  input  logic           clk,
  input  logic           rst,
  output logic [PCW-1:0] imem_addr,
  input  logic [15:0]    imem_rdata,
  output logic [3:0]     dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic [DW-1:0]  dmem_rdata,
  output logic           dmem_we,
  output logic           dmem_re,
  input  logic           dmem_ready,
  output logic           halted,
  output logic           carry,
  output logic           illegal
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_STUR = 4'h6;
  localparam logic [3:0] OP_LDUR = 4'h7;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'h9;
  localparam logic [3:0] OP_BNZ  = 4'hA;
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  state_e          state_q;
  logic [PCW-1:0]  pc_q;
  logic [15:0]     ir_q;
  logic [DW-1:0]   regs_q [NREG];
  logic            carry_q, halted_q, illegal_q;
  logic            dmem_we_q, dmem_re_q;
  logic [3:0]      dmem_addr_q;
  logic [DW-1:0]   dmem_wdata_q;

  logic [3:0]      op_f, rd_f, rn_f, rm_f;
  logic [DW-1:0]   rd_val, rn_val, rm_val;
  logic [DW-1:0]   alu_res_d;
  logic [DW:0]     sum;
  logic            carry_d, alu_wr;

  function automatic logic in_range(input logic [3:0] idx);
    return ({1'b0, idx} < 5'(NREG));
  endfunction

  assign op_f = ir_q[15:12];
  assign rd_f = ir_q[11:8];
  assign rn_f = ir_q[7:4];
  assign rm_f = ir_q[3:0];

  // Out-of-range register indices read as zero.
  assign rd_val = in_range(rd_f) ? regs_q[rd_f[AW-1:0]] : '0;
  assign rn_val = in_range(rn_f) ? regs_q[rn_f[AW-1:0]] : '0;
  assign rm_val = in_range(rm_f) ? regs_q[rm_f[AW-1:0]] : '0;

  always_comb begin
    alu_res_d = '0;
    carry_d   = carry_q;
    alu_wr    = 1'b0;
    sum       = '0;
    case (op_f)
      OP_ADD: begin
        sum       = {1'b0, rn_val} + {1'b0, rm_val};
        alu_res_d = sum[DW-1:0];
        carry_d   = sum[DW];
        alu_wr    = 1'b1;
      end
      OP_ADDI: begin
        sum       = {1'b0, rn_val} + (DW+1)'(rm_f);
        alu_res_d = sum[DW-1:0];
        carry_d   = sum[DW];
        alu_wr    = 1'b1;
      end
      OP_AND: begin
        alu_res_d = rn_val & rm_val;
        alu_wr    = 1'b1;
      end
      OP_OR: begin
        alu_res_d = rn_val | rm_val;
        alu_wr    = 1'b1;
      end
      OP_MUL: begin
        alu_res_d = rn_val * rm_val;
        alu_wr    = 1'b1;
      end
      OP_SUB: begin
        alu_res_d = rn_val - rm_val;
        carry_d   = (rn_val < rm_val);
        alu_wr    = 1'b1;
      end
      default: begin
        alu_wr = 1'b0;
      end
    endcase
  end

  // halted and illegal are predecoded at FETCH so they are valid during EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      carry_q      <= 1'b0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_re_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          ir_q      <= imem_rdata;
          illegal_q <= (imem_rdata[15:12] >= 4'hB);
          halted_q  <= (imem_rdata[15:12] == OP_HALT);
          state_q   <= S_EXEC;
        end
        S_EXEC: begin
          illegal_q <= 1'b0;
          carry_q   <= carry_d;
          if (alu_wr && in_range(rd_f)) regs_q[rd_f[AW-1:0]] <= alu_res_d;
          case (op_f)
            OP_STUR: begin
              dmem_we_q    <= 1'b1;
              dmem_addr_q  <= rd_f;
              dmem_wdata_q <= rn_val;
              state_q      <= S_MEM;
            end
            OP_LDUR: begin
              dmem_re_q   <= 1'b1;
              dmem_addr_q <= rd_f;
              state_q     <= S_MEM;
            end
            OP_BNZ: begin
              pc_q    <= (rd_val != '0) ? ir_q[PCW-1:0] : pc_q + PCW'(1);
              state_q <= S_FETCH;
            end
            OP_HALT: begin
              state_q <= S_HALT;
            end
            default: begin
              pc_q    <= pc_q + PCW'(1);
              state_q <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (dmem_re_q && in_range(rn_f)) regs_q[rn_f[AW-1:0]] <= dmem_rdata;
            dmem_we_q <= 1'b0;
            dmem_re_q <= 1'b0;
            pc_q      <= pc_q + PCW'(1);
            state_q   <= S_FETCH;
          end else begin
            state_q <= S_MEM;
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_re    = dmem_re_q;
  assign halted     = halted_q;
  assign carry      = carry_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_mcycle_cpu.sv
// Directed bench for mcycle_cpu: default-parameter core plus an NREG=4 core.
module tb_mcycle_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rom  [16];
  logic [15:0] rom4 [16];
  logic [7:0]  dmem [16];

  logic [3:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [3:0]  dmem_addr;
  logic [7:0]  dmem_wdata, dmem_rdata;
  logic        dmem_we, dmem_re, dmem_ready, halted, carry, illegal;

  logic [3:0]  imem_addr4;
  logic [15:0] imem_rdata4;
  logic [3:0]  dmem_addr4;
  logic [7:0]  dmem_wdata4;
  logic [7:0]  dmem_rdata4 = 8'h00;
  logic        dmem_ready4 = 1'b1;
  logic        dmem_we4, dmem_re4, halted4, carry4, illegal4;

  int nvec = 0;
  int nerr = 0;

  assign imem_rdata  = rom[imem_addr];
  assign imem_rdata4 = rom4[imem_addr4];
  assign dmem_rdata  = dmem[dmem_addr];

  mcycle_cpu #(.DW(8), .NREG(8), .PCW(4)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_ready(dmem_ready),
    .halted(halted), .carry(carry), .illegal(illegal)
  );

  mcycle_cpu #(.DW(8), .NREG(4), .PCW(4)) dut4 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr4), .imem_rdata(imem_rdata4),
    .dmem_addr(dmem_addr4), .dmem_wdata(dmem_wdata4), .dmem_rdata(dmem_rdata4),
    .dmem_we(dmem_we4), .dmem_re(dmem_re4), .dmem_ready(dmem_ready4),
    .halted(halted4), .carry(carry4), .illegal(illegal4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dmem_we && dmem_ready) dmem[dmem_addr] <= dmem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 16'h5000;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    dmem_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rom4[i] = 16'h5000;
      dmem[i] = 8'h00;
    end
    rom4[0] = 16'h1607;  // ADDI R6=R0+7 (discarded)
    rom4[1] = 16'h1163;  // ADDI R1=R6+3 (R6 reads 0)
    rom4[2] = 16'h9000;

    // Test 1: ADDI/ADDI/ADD/HALT and reset state
    clear_rom();
    rom[0] = 16'h1105; rom[1] = 16'h1203; rom[2] = 16'h0312; rom[3] = 16'h9000;
    #2;
    chk("rst_pc", 32'(imem_addr), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_carry", 32'(carry), 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    chk("rst_we_re", 32'({dmem_we, dmem_re}), 32'h0);
    chk("rst_daddr", 32'(dmem_addr), 32'h0);
    chk("rst_wdata", 32'(dmem_wdata), 32'h0);
    release_rst();
    tick(6);
    chk("t1_halted_6", 32'(halted), 32'h0);
    chk("t1_r3", 32'(dut.regs_q[3]), 32'h08);
    tick(1);
    chk("t1_halted_7", 32'(halted), 32'h1);
    chk("t1_carry", 32'(carry), 32'h0);
    tick(3);
    chk("t1_pc_frozen", 32'(imem_addr), 32'h3);
    chk("t1_halted_hold", 32'(halted), 32'h1);

    // Test 2: MUL to 0xFF, ADDI wrap with carry, SUB borrow, AND/OR
    @(negedge clk); rst = 1'b1;
    clear_rom();
    rom[0] = 16'h110F; rom[1] = 16'h1212; rom[2] = 16'h4112; rom[3] = 16'h1111;
    rom[4] = 16'h5000; rom[5] = 16'h1101; rom[6] = 16'h8401; rom[7] = 16'h2542;
    rom[8] = 16'h3621; rom[9] = 16'h9000;
    release_rst();
    tick(6);
    chk("t2_mul_r1", 32'(dut.regs_q[1]), 32'hFF);
    tick(2);
    chk("t2_wrap_r1", 32'(dut.regs_q[1]), 32'h00);
    chk("t2_wrap_carry", 32'(carry), 32'h1);
    tick(2);
    chk("t2_nop_carry", 32'(carry), 32'h1);
    tick(2);
    chk("t2_addi_r1", 32'(dut.regs_q[1]), 32'h01);
    chk("t2_addi_carry", 32'(carry), 32'h0);
    tick(2);
    chk("t2_sub_r4", 32'(dut.regs_q[4]), 32'hFF);
    chk("t2_sub_carry", 32'(carry), 32'h1);
    tick(2);
    chk("t2_and_r5", 32'(dut.regs_q[5]), 32'h11);
    chk("t2_and_carry", 32'(carry), 32'h1);
    tick(2);
    chk("t2_or_r6", 32'(dut.regs_q[6]), 32'h11);

    // Test 3: STUR with two wait cycles, then LDUR
    @(negedge clk); rst = 1'b1;
    clear_rom();
    rom[0] = 16'h110E; rom[1] = 16'h1203; rom[2] = 16'h4112; rom[3] = 16'h6310;
    rom[4] = 16'h7350; rom[5] = 16'h9000;
    dmem_ready = 1'b0;
    release_rst();
    tick(7);
    chk("t3_we_before", 32'(dmem_we), 32'h0);
    tick(1);
    chk("t3_we_c1", 32'(dmem_we), 32'h1);
    chk("t3_addr", 32'(dmem_addr), 32'h3);
    chk("t3_wdata", 32'(dmem_wdata), 32'h2A);
    chk("t3_re_c1", 32'(dmem_re), 32'h0);
    tick(1);
    chk("t3_we_c2", 32'(dmem_we), 32'h1);
    tick(1);
    chk("t3_we_c3", 32'(dmem_we), 32'h1);
    dmem_ready = 1'b1;
    tick(1);
    chk("t3_we_done", 32'(dmem_we), 32'h0);
    chk("t3_mem3", 32'(dmem[3]), 32'h2A);
    chk("t3_pc_after_st", 32'(imem_addr), 32'h4);
    tick(2);
    chk("t3_re", 32'(dmem_re), 32'h1);
    chk("t3_we_in_ld", 32'(dmem_we), 32'h0);
    chk("t3_ld_addr", 32'(dmem_addr), 32'h3);
    tick(1);
    chk("t3_r5", 32'(dut.regs_q[5]), 32'h2A);
    chk("t3_re_done", 32'(dmem_re), 32'h0);
    chk("t3_pc_after_ld", 32'(imem_addr), 32'h5);

    // Test 4: BNZ loop runs twice, then pc wraps past 15
    @(negedge clk); rst = 1'b1;
    clear_rom();
    rom[0] = 16'h1102; rom[1] = 16'h1201; rom[2] = 16'h8112; rom[3] = 16'h1331;
    rom[4] = 16'hA102;
    release_rst();
    tick(10);
    chk("t4_taken_pc", 32'(imem_addr), 32'h2);
    tick(6);
    chk("t4_fall_pc", 32'(imem_addr), 32'h5);
    chk("t4_iter_r3", 32'(dut.regs_q[3]), 32'h2);
    chk("t4_r1", 32'(dut.regs_q[1]), 32'h0);
    tick(20);
    chk("t4_pc15", 32'(imem_addr), 32'hF);
    tick(2);
    chk("t4_pc_wrap", 32'(imem_addr), 32'h0);

    // Test 5: reset during a stalled LDUR
    @(negedge clk); rst = 1'b1;
    clear_rom();
    rom[0] = 16'h1509; rom[1] = 16'h7450; rom[2] = 16'h9000;
    dmem[4] = 8'h77;
    dmem_ready = 1'b0;
    release_rst();
    tick(4);
    chk("t5_re", 32'(dmem_re), 32'h1);
    chk("t5_addr", 32'(dmem_addr), 32'h4);
    tick(1);
    chk("t5_re_wait", 32'(dmem_re), 32'h1);
    chk("t5_r5_wait", 32'(dut.regs_q[5]), 32'h09);
    #2 rst = 1'b1;
    #1;
    chk("t5_re_drop", 32'(dmem_re), 32'h0);
    chk("t5_pc", 32'(imem_addr), 32'h0);
    chk("t5_r5", 32'(dut.regs_q[5]), 32'h00);
    chk("t5_daddr", 32'(dmem_addr), 32'h0);

    // Test 6: illegal opcode pulse; NREG=4 out-of-range access
    clear_rom();
    rom[0] = 16'h1106; rom[1] = 16'hC123; rom[2] = 16'h9000;
    dmem_ready = 1'b1;
    release_rst();
    tick(2);
    chk("t6_r1", 32'(dut.regs_q[1]), 32'h06);
    chk("t6_illegal_pre", 32'(illegal), 32'h0);
    tick(1);
    chk("t6_illegal_on", 32'(illegal), 32'h1);
    tick(1);
    chk("t6_illegal_off", 32'(illegal), 32'h0);
    chk("t6_pc", 32'(imem_addr), 32'h2);
    chk("t6_r1_keep", 32'(dut.regs_q[1]), 32'h06);
    chk("t6_r2_keep", 32'(dut.regs_q[2]), 32'h00);
    chk("t6_n4_r1", 32'(dut4.regs_q[1]), 32'h03);
    chk("t6_n4_r2", 32'(dut4.regs_q[2]), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
